// File: rtl/mure_pkg.sv
// Shared types and widths for the MURE trace connector: FIFO entry layouts,
// record field widths and the sequencer state encoding.
package mure_pkg;

  localparam int unsigned UCNT_LEN      = 3;
  localparam int unsigned ITYPE_LEN     = 3;
  localparam int unsigned INST_LEN      = 32;
  localparam int unsigned ILASTSIZE_LEN = 1;
  localparam int unsigned CAUSE_LEN     = 5;
  localparam int unsigned XLEN          = 32;
  localparam int unsigned PRIV_LEN      = 2;

  localparam logic [UCNT_LEN-1:0] UCNT_ZERO = {UCNT_LEN{1'b0}};
  localparam logic [UCNT_LEN-1:0] UCNT_ONE  = {{(UCNT_LEN-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
    logic [PRIV_LEN-1:0]  priv;
    logic [UCNT_LEN-1:0]  uop_cnt;
  } common_entry_s;

  typedef struct packed {
    logic [ITYPE_LEN-1:0]     itype;
    logic [INST_LEN-1:0]      iaddr;
    logic                     iretire;
    logic [ILASTSIZE_LEN-1:0] ilastsize;
  } uop_entry_s;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } seq_state_e;

endpackage

// File: rtl/mure_trace_sequencer.sv
// Pairs retired uops with their block context and streams one record per cycle.
// Optional MURE_STALL_CNT_EN adds a saturating encoder back-pressure counter.
module mure_trace_sequencer
  import mure_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     common_empty_i,
  input  common_entry_s            common_entry_i,
  output logic                     common_pop_o,
  input  logic                     uop_empty_i,
  input  uop_entry_s               uop_entry_i,
  output logic                     uop_pop_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [ITYPE_LEN-1:0]     itype_o,
  output logic [INST_LEN-1:0]      iaddr_o,
  output logic                     iretire_o,
  output logic [ILASTSIZE_LEN-1:0] ilastsize_o,
  output logic [CAUSE_LEN-1:0]     cause_o,
  output logic [XLEN-1:0]          tval_o,
  output logic [PRIV_LEN-1:0]      priv_o,
  output logic                     last_o,
  output logic [31:0]              stall_cnt_o
);

  seq_state_e           state_r, state_nxt_s;
  logic [UCNT_LEN-1:0]  remaining_r, remaining_nxt_s;
  logic [CAUSE_LEN-1:0] ctx_cause_r;
  logic [XLEN-1:0]      ctx_tval_r;
  logic [PRIV_LEN-1:0]  ctx_priv_r;
  logic                 slot_free_s, latch_s, load_s;

  // Next-state, block latch and uop load decisions; pops are gated off in reset
  always_comb begin
    state_nxt_s     = state_r;
    remaining_nxt_s = remaining_r;
    latch_s         = 1'b0;
    load_s          = 1'b0;
    slot_free_s     = !valid_o || ready_i;
    if (flush_i || !rst_ni) begin
      state_nxt_s     = IDLE;
      remaining_nxt_s = UCNT_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (!common_empty_i) begin
            latch_s         = 1'b1;
            remaining_nxt_s = common_entry_i.uop_cnt;
            // an empty block is dropped without leaving IDLE
            if (common_entry_i.uop_cnt != UCNT_ZERO) begin
              state_nxt_s = EMIT;
            end else begin
              state_nxt_s = IDLE;
            end
          end else begin
            state_nxt_s = IDLE;
          end
        end
        EMIT: begin
          if (slot_free_s && !uop_empty_i && (remaining_r != UCNT_ZERO)) begin
            load_s          = 1'b1;
            remaining_nxt_s = remaining_r - UCNT_ONE;
            if (remaining_r == UCNT_ONE) begin
              state_nxt_s = IDLE;
            end else begin
              state_nxt_s = EMIT;
            end
          end else begin
            state_nxt_s = EMIT;
          end
        end
        default: begin
          state_nxt_s     = IDLE;
          remaining_nxt_s = UCNT_ZERO;
        end
      endcase
    end
  end

  assign common_pop_o = latch_s;
  assign uop_pop_o    = load_s;

  // Sequencer state, remaining count and latched block context
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      remaining_r <= UCNT_ZERO;
      ctx_cause_r <= {CAUSE_LEN{1'b0}};
      ctx_tval_r  <= {XLEN{1'b0}};
      ctx_priv_r  <= {PRIV_LEN{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      remaining_r <= remaining_nxt_s;
      if (latch_s) begin
        ctx_cause_r <= common_entry_i.cause;
        ctx_tval_r  <= common_entry_i.tval;
        ctx_priv_r  <= common_entry_i.priv;
      end else begin
        ctx_cause_r <= ctx_cause_r;
        ctx_tval_r  <= ctx_tval_r;
        ctx_priv_r  <= ctx_priv_r;
      end
    end
  end

  // Registered output record; held while the encoder back-pressures
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o     <= 1'b0;
      itype_o     <= {ITYPE_LEN{1'b0}};
      iaddr_o     <= {INST_LEN{1'b0}};
      iretire_o   <= 1'b0;
      ilastsize_o <= {ILASTSIZE_LEN{1'b0}};
      cause_o     <= {CAUSE_LEN{1'b0}};
      tval_o      <= {XLEN{1'b0}};
      priv_o      <= {PRIV_LEN{1'b0}};
      last_o      <= 1'b0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (load_s) begin
      valid_o     <= 1'b1;
      itype_o     <= uop_entry_i.itype;
      iaddr_o     <= uop_entry_i.iaddr;
      iretire_o   <= uop_entry_i.iretire;
      ilastsize_o <= uop_entry_i.ilastsize;
      cause_o     <= ctx_cause_r;
      tval_o      <= ctx_tval_r;
      priv_o      <= ctx_priv_r;
      last_o      <= (remaining_r == UCNT_ONE);
    end else if (slot_free_s) begin
      valid_o <= 1'b0;
    end else begin
      valid_o <= valid_o;
    end
  end

`ifdef MURE_STALL_CNT_EN
  logic [31:0] stall_cnt_r;

  // Saturating count of cycles the encoder refuses a valid record
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_r <= 32'h0000_0000;
    end else if (valid_o && !ready_i && (stall_cnt_r != 32'hFFFF_FFFF)) begin
      stall_cnt_r <= stall_cnt_r + 32'h0000_0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt_o = stall_cnt_r;
`else
  assign stall_cnt_o = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_mure_trace_sequencer.sv
// Scoreboard bench for mure_trace_sequencer: FIFO models feed the DUT and
// expected records are queued as blocks are pushed.
module tb_mure_trace_sequencer;
  import mure_pkg::*;

  localparam int REC_W = ITYPE_LEN + INST_LEN + 1 + ILASTSIZE_LEN + CAUSE_LEN + XLEN + PRIV_LEN + 1;
  typedef logic [REC_W-1:0] rec_t;

  logic                     clk_i = 1'b0;
  logic                     rst_ni, flush_i, common_empty_i, uop_empty_i, ready_i;
  common_entry_s            common_entry_i;
  uop_entry_s               uop_entry_i;
  logic                     common_pop_o, uop_pop_o, valid_o, iretire_o, last_o;
  logic [ITYPE_LEN-1:0]     itype_o;
  logic [INST_LEN-1:0]      iaddr_o;
  logic [ILASTSIZE_LEN-1:0] ilastsize_o;
  logic [CAUSE_LEN-1:0]     cause_o;
  logic [XLEN-1:0]          tval_o;
  logic [PRIV_LEN-1:0]      priv_o;
  logic [31:0]              stall_cnt_o;

  int n_cmp = 0, n_err = 0, rec_cnt = 0, cpop_cnt = 0, upop_cnt = 0, cyc = 0;
  int rec_cyc[$];
  common_entry_s cq[$];
  uop_entry_s    uq[$], held_q[$];
  rec_t          exp_q[$];
  logic cpop_pend = 1'b0, upop_pend = 1'b0;
  logic [31:0] addr_seed = 32'h8000_0000;

  mure_trace_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .common_empty_i(common_empty_i), .common_entry_i(common_entry_i), .common_pop_o(common_pop_o),
    .uop_empty_i(uop_empty_i), .uop_entry_i(uop_entry_i), .uop_pop_o(uop_pop_o),
    .valid_o(valid_o), .ready_i(ready_i), .itype_o(itype_o), .iaddr_o(iaddr_o),
    .iretire_o(iretire_o), .ilastsize_o(ilastsize_o), .cause_o(cause_o), .tval_o(tval_o),
    .priv_o(priv_o), .last_o(last_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    common_empty_i = (cq.size() == 0);
    uop_empty_i    = (uq.size() == 0);
    if (cq.size() > 0) common_entry_i = cq[0]; else common_entry_i = '0;
    if (uq.size() > 0) uop_entry_i = uq[0]; else uop_entry_i = '0;
  endtask

  // Monitor: sample pops and accepted records away from the active edge
  always @(negedge clk_i) begin
    rec_t e;
    cpop_pend = common_pop_o;
    upop_pend = uop_pop_o;
    if (common_pop_o) cpop_cnt++;
    if (uop_pop_o) upop_cnt++;
    if (rst_ni && valid_o && ready_i) begin
      rec_cnt++;
      rec_cyc.push_back(cyc);
      check("scoreboard_has_entry", 128'(exp_q.size() > 0), 128'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("record", {itype_o, iaddr_o, iretire_o, ilastsize_o, cause_o, tval_o, priv_o, last_o}, e);
      end
    end
  end

  // FIFO models: apply sampled pops after the edge, then present new heads
  always @(posedge clk_i) begin
    cyc++;
    #1;
    if (cpop_pend && cq.size() > 0) cq.delete(0);
    if (upop_pend && uq.size() > 0) uq.delete(0);
    cpop_pend = 1'b0;
    upop_pend = 1'b0;
    #1;
    refresh();
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_block(input logic [CAUSE_LEN-1:0] cause, input logic [XLEN-1:0] tval,
                            input logic [PRIV_LEN-1:0] priv, input int cnt, input int n_now);
    common_entry_s c;
    uop_entry_s u;
    c.cause = cause; c.tval = tval; c.priv = priv; c.uop_cnt = UCNT_LEN'(cnt);
    cq.push_back(c);
    for (int i = 0; i < cnt; i++) begin
      u.itype     = ITYPE_LEN'($urandom_range(0, 7));
      u.iaddr     = addr_seed;
      u.iretire   = 1'($urandom_range(0, 1));
      u.ilastsize = ILASTSIZE_LEN'($urandom_range(0, 1));
      addr_seed   = addr_seed + 32'd4;
      exp_q.push_back({u.itype, u.iaddr, u.iretire, u.ilastsize, cause, tval, priv, (i == cnt - 1)});
      if (i < n_now) uq.push_back(u); else held_q.push_back(u);
    end
  endtask

  task automatic wait_recs(input string tag, input int n);
    int budget;
    budget = 200;
    while (rec_cnt < n && budget > 0) begin
      tick();
      budget--;
    end
    check(tag, 128'(rec_cnt), 128'(n));
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, 128'(valid_o), 128'd0);
    check({tag, "_last"}, 128'(last_o), 128'd0);
    check({tag, "_record"}, {itype_o, iaddr_o, iretire_o, ilastsize_o, cause_o, tval_o, priv_o}, 128'd0);
    check({tag, "_stall_cnt"}, 128'(stall_cnt_o), 128'd0);
    check({tag, "_pops"}, 128'({common_pop_o, uop_pop_o}), 128'd0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, c0, u0;
    logic [31:0] s0;
    logic [INST_LEN-1:0] held_addr;
    rst_ni = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    refresh();
    repeat (3) tick();
    check_zero_outputs("reset");
    check("reset_state", 128'(dut.state_r), 128'(IDLE));
    rst_ni = 1'b1;
    tick();

    // 1: three-uop block at full throughput
    base = rec_cnt; c0 = cpop_cnt; u0 = upop_cnt;
    push_block(5'd2, 32'h80, 2'd3, 3, 3);
    wait_recs("t1_records", base + 3);
    check("t1_back_to_back", 128'(rec_cyc[base + 2] - rec_cyc[base]), 128'd2);
    check("t1_common_pops", 128'(cpop_cnt - c0), 128'd1);
    check("t1_uop_pops", 128'(upop_cnt - u0), 128'd3);
    repeat (2) tick();

    // 2: back-pressure on the second record
    base = rec_cnt;
    push_block(5'd2, 32'h80, 2'd3, 3, 3);
    wait_recs("t2_first", base + 1);
    ready_i = 1'b0;
    s0 = stall_cnt_o; u0 = upop_cnt; held_addr = iaddr_o;
    repeat (4) tick();
    check("t2_held_valid", 128'(valid_o), 128'd1);
    check("t2_held_addr", 128'(iaddr_o), 128'(held_addr));
    check("t2_no_pop_stall", 128'(upop_cnt - u0), 128'd0);
`ifdef MURE_STALL_CNT_EN
    check("t2_stall_cnt", 128'(stall_cnt_o - s0), 128'd4);
`else
    check("t2_stall_cnt", 128'(stall_cnt_o), 128'd0);
`endif
    ready_i = 1'b1;
    wait_recs("t2_rest", base + 3);
    repeat (2) tick();

    // 3: empty block is discarded, single-uop block follows
    base = rec_cnt;
    push_block(5'd7, 32'h44, 2'd0, 0, 0);
    push_block(5'd3, 32'h55, 2'd1, 1, 1);
    wait_recs("t3_one_record", base + 1);
    repeat (4) tick();
    check("t3_no_extra", 128'(rec_cnt), 128'(base + 1));

    // 4: block starves mid-way and resumes with its context
    base = rec_cnt;
    push_block(5'd9, 32'hdead_beef, 2'd1, 2, 1);
    wait_recs("t4_first", base + 1);
    repeat (5) tick();
    check("t4_idle_valid", 128'(valid_o), 128'd0);
    check("t4_wait_emit", 128'(dut.state_r), 128'(EMIT));
    uq.push_back(held_q.pop_front());
    wait_recs("t4_second", base + 2);
    repeat (2) tick();

    // 5: flush after first record
    base = rec_cnt;
    push_block(5'd4, 32'h1234, 2'd2, 3, 3);
    wait_recs("t5_first", base + 1);
    flush_i = 1'b1; ready_i = 1'b0;
    cq.delete(); uq.delete(); exp_q.delete();
    tick();
    flush_i = 1'b0; ready_i = 1'b1;
    check("t5_valid_cleared", 128'(valid_o), 128'd0);
    check("t5_state_idle", 128'(dut.state_r), 128'(IDLE));
    base = rec_cnt;
    push_block(5'd6, 32'h5678, 2'd0, 2, 2);
    wait_recs("t5_after_flush", base + 2);
    repeat (2) tick();

    // 6: asynchronous reset in the middle of a block
    base = rec_cnt;
    push_block(5'd1, 32'h9999, 2'd3, 3, 3);
    wait_recs("t6_first", base + 1);
    ready_i = 1'b0;
    repeat (2) tick();
    rst_ni = 1'b0;
    cq.delete(); uq.delete(); held_q.delete(); exp_q.delete();
    #1;
    check_zero_outputs("t6_reset");
    tick();
    rst_ni = 1'b1; ready_i = 1'b1;
    tick();
    base = rec_cnt;
    push_block(5'd8, 32'h0abc, 2'd1, 2, 2);
    wait_recs("t6_after_reset", base + 2);
    repeat (3) tick();
    check("final_drained", 128'(exp_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
